// File: rtl/pia_port_peer_if.sv
// pia_port_peer_if
// Bundles the signals between pia_port_peer, its local logic and the PIA
// it serves.
//
// Signals:
//   tx_data / tx_valid / tx_ready           byte stream into PIA port A
//   rx_data / rx_valid / rx_ready / rx_count byte stream out of PIA port B (FIFO head)
//   pa_o, ca1_o                              to PIA pa_i, ca1_i
//   ca2_i                                    from PIA ca2_o (1 = PIA holds unread data)
//   pb_i, cb2_i                              from PIA pb_o, cb2_o (cb2 low = data ready)
//   cb1_o                                    to PIA cb1_i (acknowledge strobe)
//
// Modports:
//   slave  - view used by pia_port_peer itself
//   master - view used by the surrounding logic / PIA side
interface pia_port_peer_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [CNT_W-1:0] rx_count;
   logic [7:0]       pa_o;
   logic             ca1_o;
   logic             ca2_i;
   logic [7:0]       pb_i;
   logic             cb2_i;
   logic             cb1_o;

   modport slave (
      input  tx_data, tx_valid, rx_ready, ca2_i, pb_i, cb2_i,
      output tx_ready, rx_data, rx_valid, rx_count, pa_o, ca1_o, cb1_o
   );

   modport master (
      output tx_data, tx_valid, rx_ready, ca2_i, pb_i, cb2_i,
      input  tx_ready, rx_data, rx_valid, rx_count, pa_o, ca1_o, cb1_o
   );
endinterface

// File: rtl/pia_port_peer.sv
// pia_port_peer
// Peripheral-side handshake partner for a 6821 PIA. Bytes from the tx stream
// are presented on port A and strobed in with CA1; the PIA's CA2 level tells
// us when the CPU has consumed them. Bytes offered by the PIA on port B
// (CB2 low) are captured, pushed into a small first-word-fall-through FIFO
// and acknowledged with a CB1 strobe.
//
// Ports:
//   clk  - system clock (shared with the PIA)
//   rst  - synchronous, active-high reset
//   bus  - pia_port_peer_if.slave: tx/rx byte streams and PIA handshake lines
module pia_port_peer #(
   parameter int DEPTH         = 4,
   parameter int STROBE_CYCLES = 12,
   parameter int SETUP_CYCLES  = 2,
   parameter bit CA1_RISING    = 1'b0,
   parameter bit CB1_RISING    = 1'b0
) (
   input logic            clk,
   input logic            rst,
   pia_port_peer_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TMAX  = (STROBE_CYCLES > SETUP_CYCLES) ? STROBE_CYCLES : SETUP_CYCLES;
   localparam int CW    = $clog2(TMAX + 1);
   // Down-counters are loaded with length-1 and the state advances when they hit 0.
   localparam logic [CW-1:0] STB_LD = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] SET_LD = (SETUP_CYCLES > 0) ? CW'(SETUP_CYCLES - 1) : '0;

   // ---------------- TX path ----------------
   typedef enum logic [2:0] {
      T_IDLE, T_SETUP, T_STROBE, T_RECOVER, T_WAIT_FULL, T_WAIT_EMPTY
   } tx_state_t;

   tx_state_t      tx_state, tx_state_nx;
   logic [CW-1:0]  tx_cnt, tx_cnt_nx;
   logic [7:0]     pa_q;
   logic           tx_ready_c;
   logic           tx_accept;
   logic           ca1_c;

   assign tx_accept = bus.tx_valid && tx_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= T_IDLE;
         tx_cnt   <= '0;
         pa_q     <= 8'h00;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         if (tx_accept) pa_q <= bus.tx_data;
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      case (tx_state)
         T_IDLE:
            if (tx_accept) begin
               if (SETUP_CYCLES > 0) begin
                  tx_state_nx = T_SETUP;
                  tx_cnt_nx   = SET_LD;
               end else begin
                  tx_state_nx = T_STROBE;
                  tx_cnt_nx   = STB_LD;
               end
            end
         T_SETUP:
            if (tx_cnt == '0) begin
               tx_state_nx = T_STROBE;
               tx_cnt_nx   = STB_LD;
            end else tx_cnt_nx = tx_cnt - CW'(1);
         T_STROBE:
            if (tx_cnt == '0) begin
               tx_state_nx = T_RECOVER;
               tx_cnt_nx   = STB_LD;
            end else tx_cnt_nx = tx_cnt - CW'(1);
         T_RECOVER:
            if (tx_cnt == '0) tx_state_nx = T_WAIT_FULL;
            else              tx_cnt_nx   = tx_cnt - CW'(1);
         // A PIA not in handshake mode never toggles CA2, so these waits are unbounded.
         T_WAIT_FULL:  if (bus.ca2_i)  tx_state_nx = T_WAIT_EMPTY;
         T_WAIT_EMPTY: if (!bus.ca2_i) tx_state_nx = T_IDLE;
         default:      tx_state_nx = T_IDLE;
      endcase
   end

   always_comb begin
      tx_ready_c = (tx_state == T_IDLE) && !bus.ca2_i;
      ca1_c      = (tx_state == T_STROBE) ? CA1_RISING : !CA1_RISING;
   end

   assign bus.tx_ready = tx_ready_c;
   assign bus.pa_o     = pa_q;
   assign bus.ca1_o    = ca1_c;

   // ---------------- RX path ----------------
   typedef enum logic [1:0] {R_IDLE, R_PUSH, R_STROBE, R_RECOVER} rx_state_t;

   rx_state_t        rx_state, rx_state_nx;
   logic [CW-1:0]    rx_cnt, rx_cnt_nx;
   logic             armed;
   logic [7:0]       hold;
   logic             capture, push, pop;
   logic             cb1_c;
   logic [7:0]       mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;

   // armed requires CB2 to have been seen high, so a CB2 stuck low from reset
   // (or left low after our own capture) never produces a spurious byte.
   assign capture = (rx_state == R_IDLE) && armed && !bus.cb2_i;
   // Fullness uses the registered count: a same-cycle pop only unblocks next cycle.
   assign push    = (rx_state == R_PUSH) && (count < CNT_W'(DEPTH));
   assign pop     = (count != '0) && bus.rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
         armed    <= 1'b0;
         hold     <= 8'h00;
      end else begin
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         if (bus.cb2_i)    armed <= 1'b1;
         else if (capture) armed <= 1'b0;
         if (capture) hold <= bus.pb_i;
      end
   end

   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      case (rx_state)
         R_IDLE: if (capture) rx_state_nx = R_PUSH;
         // Holding here withholds CB1, which keeps CB2 low and stalls the CPU.
         R_PUSH:
            if (push) begin
               rx_state_nx = R_STROBE;
               rx_cnt_nx   = STB_LD;
            end
         R_STROBE:
            if (rx_cnt == '0) begin
               rx_state_nx = R_RECOVER;
               rx_cnt_nx   = STB_LD;
            end else rx_cnt_nx = rx_cnt - CW'(1);
         R_RECOVER:
            if (rx_cnt == '0) rx_state_nx = R_IDLE;
            else              rx_cnt_nx   = rx_cnt - CW'(1);
         default: rx_state_nx = R_IDLE;
      endcase
   end

   always_comb begin
      cb1_c = (rx_state == R_STROBE) ? CB1_RISING : !CB1_RISING;
   end

   // FIFO storage is cleared on reset so the head reads 0x00 afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         if (push) begin
            mem[wr_ptr] <= hold;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign bus.rx_data  = mem[rd_ptr];
   assign bus.rx_valid = (count != '0);
   assign bus.rx_count = count;
   assign bus.cb1_o    = cb1_c;
endmodule

// File: tb/tb_pia_port_peer.sv
// tb_pia_port_peer
// Directed bench for pia_port_peer with default parameters
// (DEPTH=4, STROBE_CYCLES=12, SETUP_CYCLES=2, active-low strobes).
module tb_pia_port_peer;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   lowcnt;
   int   seen;

   pia_port_peer_if #(.DEPTH(4)) bus ();

   pia_port_peer #(
      .DEPTH(4), .STROBE_CYCLES(12), .SETUP_CYCLES(2),
      .CA1_RISING(1'b0), .CB1_RISING(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one byte on port B, wait through capture, push and both strobe phases.
   task automatic send_rx(input logic [7:0] b);
      bus.pb_i  = b;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      ticks(26);
   endtask

   task automatic pop_one();
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b0;
      bus.ca2_i    = 1'b0;
      bus.pb_i     = 8'h00;
      bus.cb2_i    = 1'b0;
      ticks(2);

      chk("rst_pa_o",     bus.pa_o,     8'h00);
      chk("rst_ca1_o",    bus.ca1_o,    1'b1);
      chk("rst_cb1_o",    bus.cb1_o,    1'b1);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_rx_count", bus.rx_count, 0);
      chk("rst_rx_data",  bus.rx_data,  8'h00);
      chk("rst_tx_ready", bus.tx_ready, 1'b1);

      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.cb1_o !== 1'b1 || bus.rx_valid !== 1'b0) seen++;
      end
      chk("cb2_low_no_capture", seen, 0);

      // TX 0xA5, accepted at edge n
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      chk("tx_pa_o", bus.pa_o, 8'hA5);
      chk("tx_ready_busy", bus.tx_ready, 1'b0);
      tick();
      chk("tx_ca1_setup", bus.ca1_o, 1'b1);
      lowcnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.ca1_o === 1'b0) lowcnt++;
      end
      chk("tx_ca1_low_len", lowcnt, 12);
      tick();
      chk("tx_ca1_end", bus.ca1_o, 1'b1);

      bus.ca2_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.tx_ready !== 1'b0) seen++;
      end
      chk("tx_ready_held_ca2", seen, 0);
      bus.ca2_i = 1'b0;
      #1;
      chk("tx_ready_before_edge", bus.tx_ready, 1'b0);
      tick();
      chk("tx_ready_after_drop", bus.tx_ready, 1'b1);

      // RX 0x3C, captured at edge c
      bus.pb_i  = 8'h3C;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      chk("rx_valid_c1", bus.rx_valid, 1'b0);
      tick();
      chk("rx_valid", bus.rx_valid, 1'b1);
      chk("rx_data",  bus.rx_data,  8'h3C);
      chk("rx_count1", bus.rx_count, 1);
      lowcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.cb1_o === 1'b0) lowcnt++;
         tick();
      end
      chk("rx_cb1_low_len", lowcnt, 12);
      chk("rx_cb1_end", bus.cb1_o, 1'b1);
      pop_one();
      chk("rx_popped_empty", bus.rx_valid, 1'b0);
      ticks(14);

      // Back-pressure
      send_rx(8'h01);
      send_rx(8'h02);
      send_rx(8'h03);
      send_rx(8'h04);
      chk("bp_count_full", bus.rx_count, 4);
      chk("bp_head",       bus.rx_data,  8'h01);
      bus.pb_i  = 8'h05;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.cb1_o !== 1'b1) seen++;
      end
      chk("bp_no_strobe", seen, 0);
      chk("bp_count_stuck", bus.rx_count, 4);
      pop_one();
      ticks(2);
      chk("bp_strobe_after_pop", bus.cb1_o, 1'b0);
      chk("bp_count_refill", bus.rx_count, 4);
      chk("bp_pop_02", bus.rx_data, 8'h02);
      pop_one();
      chk("bp_pop_03", bus.rx_data, 8'h03);
      pop_one();
      chk("bp_pop_04", bus.rx_data, 8'h04);
      pop_one();
      chk("bp_pop_05", bus.rx_data, 8'h05);
      pop_one();
      chk("bp_drained", bus.rx_valid, 1'b0);
      ticks(26);

      // Re-arm during R_RECOVER
      bus.pb_i  = 8'h11;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      ticks(16);
      bus.pb_i  = 8'h77;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      ticks(30);
      chk("rearm_count", bus.rx_count, 2);
      chk("rearm_first", bus.rx_data, 8'h11);
      pop_one();
      chk("rearm_second", bus.rx_data, 8'h77);
      pop_one();
      ticks(2);

      // Reset mid-T_STROBE and mid-R_PUSH
      send_rx(8'hA1);
      send_rx(8'hA2);
      send_rx(8'hA3);
      send_rx(8'hA4);
      bus.pb_i  = 8'hA5;
      bus.cb2_i = 1'b1;
      tick();
      bus.cb2_i = 1'b0;
      tick();
      bus.tx_data  = 8'h5A;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      ticks(5);
      chk("pre_rst_ca1_active", bus.ca1_o, 1'b0);
      chk("pre_rst_count", bus.rx_count, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ca1_o",    bus.ca1_o,    1'b1);
      chk("mid_rst_pa_o",     bus.pa_o,     8'h00);
      chk("mid_rst_rx_count", bus.rx_count, 0);
      chk("mid_rst_rx_data",  bus.rx_data,  8'h00);
      chk("mid_rst_cb1_o",    bus.cb1_o,    1'b1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.cb1_o !== 1'b1 || bus.ca1_o !== 1'b1 || bus.rx_count !== 0) seen++;
      end
      chk("post_rst_quiet", seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pia_port_peer.md
# pia_port_peer

Peripheral-side handshake partner for a `pia_6821` instance. It feeds bytes into PIA port A using the CA1/CA2 input handshake, and takes bytes out of PIA port B using the CB2/CB1 output handshake. Its role matches the sound/IO boards in the cabinet model, and it also serves as the bench-side peer for PIA tests. It sits next to the PIA on the same system clock and presents valid/ready byte streams to local logic.

## Interface
Parameters:
- `DEPTH`, 4: RX FIFO entries; must be a power of two, ≥2.
- `STROBE_CYCLES`, 12: clk cycles each strobe stays active, and the minimum idle time between strobes. Must be ≥1. Must also be ≥ one E period so the PIA's `en_e_n`-gated sampling sees the strobe.
- `SETUP_CYCLES`, 2: cycles `pa_o` is held stable before CA1 activates; 0 allowed.
- `CA1_RISING`, 0: 1 gives a rising active edge on `ca1_o` (idle low). 0 gives falling (idle high). Must match PIA CRA[1].
- `CB1_RISING`, 0: same rule for `cb1_o` against CRB[1].

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to deliver to port A.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: byte accepted this cycle when `tx_valid` is also high.
- `rx_data` out 8: FIFO head byte.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pop the head byte when `rx_valid` is high.
- `rx_count` out clog2(DEPTH+1): FIFO occupancy.
- `pa_o` out 8: drives PIA `pa_i`.
- `ca1_o` out 1: drives PIA `ca1_i`.
- `ca2_i` in 1: from PIA `ca2_o`. High means the PIA holds unread data; low means it is empty.
- `pb_i` in 8: from PIA `pb_o`.
- `cb2_i` in 1: from PIA `cb2_o`. Low means data is ready.
- `cb1_o` out 1: drives PIA `cb1_i`; this is the acknowledge strobe.

## Operation
TX FSM, states T_IDLE → T_SETUP → T_STROBE → T_RECOVER → T_WAIT_FULL → T_WAIT_EMPTY → T_IDLE:
- `tx_ready` = (state==T_IDLE) && !ca2_i. This is combinational.
- On accept: latch `tx_data` into `pa_o`.
- T_SETUP lasts SETUP_CYCLES; it is skipped when that value is 0.
- T_STROBE drives `ca1_o` to its active level for STROBE_CYCLES.
- T_RECOVER drives `ca1_o` to its idle level for STROBE_CYCLES.
- T_WAIT_FULL waits for `ca2_i`=1, i.e. the PIA has latched the edge.
- T_WAIT_EMPTY waits for `ca2_i`=0, i.e. the CPU has read PA.
- If the PIA is not in handshake mode, the FSM waits indefinitely; only `rst` recovers it.
- `pa_o` holds the last byte until the next accept.

RX FSM, states R_IDLE → R_PUSH → R_STROBE → R_RECOVER → R_IDLE:
- `armed` flag:
  - Set in any state when `cb2_i`=1 is sampled.
  - Cleared on capture.
  - Reset value 0, so a CB2 held low from reset never produces a capture.
- In R_IDLE, when `armed` && !cb2_i: capture `pb_i` into the holding register, clear `armed`, go to R_PUSH.
- In R_PUSH, if the FIFO is not full (registered count < DEPTH), write the holding register and go to R_STROBE. Otherwise stay in R_PUSH.
  - Withholding CB1 keeps CB2 low, which back-pressures the CPU.
- R_STROBE drives `cb1_o` active for STROBE_CYCLES; R_RECOVER drives it idle for STROBE_CYCLES.
- A CB2 rise followed by a fall during R_STROBE/R_RECOVER re-arms the FSM. That byte is captured on R_IDLE entry and is never lost.

RX FIFO rules:
- First-word-fall-through; `rx_data` is the registered head.
- A pop occurs when `rx_valid` && `rx_ready`.
- Push and pop in the same cycle are both honoured when not full.
- Fullness is judged on the registered count. A pop in the same cycle as a blocked push frees the slot, and the push completes on the next cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `pa_o`=0x00.
  - `ca1_o`=!CA1_RISING, `cb1_o`=!CB1_RISING.
  - `rx_valid`=0, `rx_count`=0, `rx_data`=0x00.
  - Both FSMs in IDLE; `tx_ready` follows !ca2_i.
- Reset mid-operation: all outputs return to their reset values on the next edge, and any captured byte is discarded.
- TX, with accept at edge n:
  - `pa_o` is valid at n+1.
  - `ca1_o` is active from n+1+SETUP_CYCLES for exactly STROBE_CYCLES.
  - The earliest next accept is at n+1+SETUP+2·STROBE, gated by the CA2 high→low sequence.
- RX, with capture at edge c:
  - Push at c+1 when not full.
  - `rx_valid`/`rx_count` update at c+2.
  - `cb1_o` is active from c+2 for STROBE_CYCLES.
- Minimum RX byte period: 2+2·STROBE_CYCLES cycles.

## Test plan
- Reset (CA1_RISING=CB1_RISING=0, `ca2_i`=0, `cb2_i`=0): `pa_o`=0x00, `ca1_o`=1, `cb1_o`=1, `rx_valid`=0, `tx_ready`=1. Holding `cb2_i` low for 100 cycles produces no capture.
- TX of 0xA5 accepted at n: `pa_o`=0xA5 at n+1, `ca1_o` low for cycles n+3..n+14. Then raise `ca2_i` and drop it 20 cycles later: `tx_ready` rises only after the drop.
- RX: `cb2_i` high, then low with `pb_i`=0x3C at c: `rx_valid`=1 and `rx_data`=0x3C at c+2, `cb1_o` low for cycles c+2..c+13.
- Back-pressure, `rx_ready`=0: bytes 0x01–0x04 fill the FIFO (`rx_count`=4). Byte 0x05 gets no CB1 strobe. After one pop, the strobe starts within 2 cycles, and the pops read 0x02, 0x03, 0x04, 0x05 in order.
- CB2 pulses high then low again during R_RECOVER with `pb_i`=0x77: 0x77 is captured on R_IDLE entry and `rx_count` increments.
- Assert `rst` mid-T_STROBE and mid-R_PUSH: next cycle `ca1_o`=1, `pa_o`=0, `rx_count`=0, no `cb1_o` strobe.
